// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - self-synchronising x^7+x^3+1 PRBS receiver/checker with lock monitor
module prbs7_checker #(
    parameter int SYNC_LEN    = 16,
    parameter int WIN         = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_in,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
    output logic [1:0]       state
);

    localparam int WC_W = $clog2(WIN);
    localparam int WE_W = $clog2(LOSS_THRESH + 1);
    localparam logic [7:0] OK_TARGET = 8'(SYNC_LEN);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t          st, st_n;
    logic [7:1]      h, h_n;
    logic [2:0]      fill, fill_n;
    logic [7:0]      ok, ok_n;
    logic [WC_W-1:0] win_cnt, win_cnt_n;
    logic [WE_W-1:0] win_err, win_err_n, win_err_inc;
    logic            exp_bit, mismatch, pulse_n;

    assign exp_bit     = h[7] ^ h[3];
    assign mismatch    = en && (st == LOCKED) && (bit_in != exp_bit);
    assign win_err_inc = win_err + WE_W'(mismatch);
    assign locked      = (st == LOCKED);
    assign state       = st;

    always_comb begin
        st_n      = st;
        h_n       = h;
        fill_n    = fill;
        ok_n      = ok;
        win_cnt_n = win_cnt;
        win_err_n = win_err;
        pulse_n   = 1'b0;
        if (en) begin
            case (st)
                SEARCH: begin
                    h_n    = {h[6:1], bit_in};
                    fill_n = (fill == 3'd7) ? 3'd7 : fill + 3'd1;
                    // an all-zero history is the LFSR lock-up state and is never accepted
                    if (fill_n == 3'd7 && h_n != '0) begin
                        st_n = VERIFY;
                        ok_n = '0;
                    end
                end
                VERIFY: begin
                    h_n = {h[6:1], bit_in};
                    if (h_n == '0) begin
                        st_n   = SEARCH;
                        fill_n = '0;
                        ok_n   = '0;
                    end else if (bit_in == exp_bit) begin
                        ok_n = ok + 8'd1;
                        if (ok_n == OK_TARGET) begin
                            st_n      = LOCKED;
                            win_cnt_n = '0;
                            win_err_n = '0;
                        end
                    end else begin
                        ok_n = '0;
                    end
                end
                LOCKED: begin
                    // feed back the prediction so line errors never corrupt the history
                    h_n     = {h[6:1], exp_bit};
                    pulse_n = mismatch;
                    if (win_err_inc >= WE_W'(LOSS_THRESH)) begin
                        st_n   = SEARCH;
                        fill_n = '0;
                        ok_n   = '0;
                    end else if (win_cnt == WC_W'(WIN - 1)) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                    end else begin
                        win_cnt_n = win_cnt + WC_W'(1);
                        win_err_n = win_err_inc;
                    end
                end
                default: st_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= SEARCH;
            h         <= '0;
            fill      <= '0;
            ok        <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            st        <= st_n;
            h         <= h_n;
            fill      <= fill_n;
            ok        <= ok_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            err_pulse <= pulse_n;
            if (clr) begin
                err_count <= '0;
                bit_count <= '0;
            end else if (en && st == LOCKED) begin
                if (mismatch && err_count != '1)
                    err_count <= err_count + CNT_W'(1);
                if (bit_count != '1)
                    bit_count <= bit_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - randomized self-checking bench for prbs7_checker against a reference model
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        rst, en, bit_in, clr;
    logic        d_locked, d_err_pulse, s_locked, s_err_pulse;
    logic [15:0] d_err_count, d_bit_count;
    logic [3:0]  s_err_count, s_bit_count;
    logic [1:0]  d_state, s_state;

    int n_cmp = 0;
    int n_err = 0;

    prbs7_checker dut (
        .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr(clr),
        .locked(d_locked), .err_pulse(d_err_pulse), .err_count(d_err_count),
        .bit_count(d_bit_count), .state(d_state)
    );

    prbs7_checker #(.SYNC_LEN(16), .WIN(64), .LOSS_THRESH(64), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr(clr),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
        .bit_count(s_bit_count), .state(s_state)
    );

    always #5 clk = ~clk;

    // index 0 models dut, index 1 models dut_sat
    int p_sync [2] = '{16, 16};
    int p_win  [2] = '{64, 64};
    int p_th   [2] = '{8, 64};
    int p_max  [2] = '{65535, 15};

    int m_st [2], m_fill [2], m_ok [2], m_wc [2], m_we [2], m_ec [2], m_bc [2];
    bit m_pulse [2];
    bit mh [2][1:7];

    bit sq [$];
    int sidx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_fill[i] = 0; m_ok[i] = 0; m_wc[i] = 0; m_we[i] = 0;
            m_ec[i] = 0; m_bc[i] = 0; m_pulse[i] = 0;
            for (int k = 1; k <= 7; k++) mh[i][k] = 0;
        end
    endtask

    function automatic bit hist_zero(input int i);
        for (int k = 1; k <= 7; k++) if (mh[i][k]) return 0;
        return 1;
    endfunction

    task automatic push(input int i, input bit b);
        for (int k = 7; k >= 2; k--) mh[i][k] = mh[i][k-1];
        mh[i][1] = b;
    endtask

    task automatic model_step(input int i, input bit e, input bit b, input bit c);
        bit ex, mis;
        m_pulse[i] = 0;
        if (e) begin
            ex = mh[i][7] ^ mh[i][3];
            if (m_st[i] == 0) begin
                push(i, b);
                if (m_fill[i] < 7) m_fill[i]++;
                if (m_fill[i] == 7 && !hist_zero(i)) begin m_st[i] = 1; m_ok[i] = 0; end
            end else if (m_st[i] == 1) begin
                push(i, b);
                if (hist_zero(i)) begin m_st[i] = 0; m_fill[i] = 0; m_ok[i] = 0; end
                else if (b == ex) begin
                    m_ok[i]++;
                    if (m_ok[i] == p_sync[i]) begin m_st[i] = 2; m_wc[i] = 0; m_we[i] = 0; end
                end else m_ok[i] = 0;
            end else begin
                mis = (b != ex);
                push(i, ex);
                m_pulse[i] = mis;
                if (m_ec[i] + int'(mis) <= p_max[i]) m_ec[i] += int'(mis);
                if (m_bc[i] < p_max[i]) m_bc[i]++;
                if (m_we[i] + int'(mis) >= p_th[i]) begin m_st[i] = 0; m_fill[i] = 0; m_ok[i] = 0; end
                else if (m_wc[i] == p_win[i] - 1) begin m_wc[i] = 0; m_we[i] = 0; end
                else begin m_wc[i]++; m_we[i] += int'(mis); end
            end
        end
        if (c) begin m_ec[i] = 0; m_bc[i] = 0; end
    endtask

    task automatic compare_all();
        check("d_state", 32'(d_state), m_st[0]);
        check("d_locked", 32'(d_locked), 32'(m_st[0] == 2));
        check("d_err_pulse", 32'(d_err_pulse), 32'(m_pulse[0]));
        check("d_err_count", 32'(d_err_count), m_ec[0]);
        check("d_bit_count", 32'(d_bit_count), m_bc[0]);
        check("s_state", 32'(s_state), m_st[1]);
        check("s_locked", 32'(s_locked), 32'(m_st[1] == 2));
        check("s_err_pulse", 32'(s_err_pulse), 32'(m_pulse[1]));
        check("s_err_count", 32'(s_err_count), m_ec[1]);
        check("s_bit_count", 32'(s_bit_count), m_bc[1]);
    endtask

    task automatic tick(input bit e, input bit b, input bit c);
        en = e; bit_in = b; clr = c;
        @(posedge clk);
        model_step(0, e, b, c);
        model_step(1, e, b, c);
        #1;
        compare_all();
    endtask

    task automatic new_stream(input logic [6:0] seed);
        sq.delete();
        for (int k = 0; k < 7; k++) sq.push_back(seed[k]);
        sidx = 0;
    endtask

    // generator recurrence b(n) = b(n-7) ^ b(n-3)
    task automatic send(input bit flip, input bit c);
        bit b;
        if (sidx == sq.size()) sq.push_back(sq[sidx-7] ^ sq[sidx-3]);
        b = sq[sidx];
        sidx++;
        tick(1'b1, b ^ flip, c);
    endtask

    task automatic rand_stream();
        logic [6:0] sd;
        do sd = 7'($urandom); while (sd == 7'd0);
        new_stream(sd);
    endtask

    task automatic do_reset();
        en = 0; bit_in = 0; clr = 0; rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst = 0;
    endtask

    task automatic pick(input int n, output logic [63:0] m);
        int cnt, p;
        m = '0; cnt = 0;
        while (cnt < n) begin
            p = $urandom_range(0, 63);
            if (!m[p]) begin m[p] = 1'b1; cnt++; end
        end
    endtask

    initial begin
        logic [63:0] mask;
        int pulses, last;

        rst = 1; en = 0; bit_in = 0; clr = 0;
        model_reset();
        #2;
        check("reset_state", 32'(d_state), 0);
        check("reset_err_count", 32'(d_err_count), 0);
        do_reset();

        // lock on the seed 7'h01 stream
        new_stream(7'h01);
        for (int i = 1; i <= 7; i++) begin
            send(0, 0);
            if (i == 6) check("fill6_search", 32'(d_state), 0);
        end
        check("fill7_verify", 32'(d_state), 1);
        for (int i = 8; i <= 23; i++) begin
            send(0, 0);
            if (i == 22) check("bit22_unlocked", 32'(d_locked), 0);
        end
        check("bit23_locked", 32'(d_locked), 1);
        for (int i = 24; i <= 100; i++) send(0, 0);
        check("lock_err_count", 32'(d_err_count), 0);
        check("lock_bit_count", 32'(d_bit_count), 77);
        check("sat_bit_count", 32'(s_bit_count), 15);

        // single error, history must survive
        send(1, 0);
        check("single_pulse", 32'(d_err_pulse), 1);
        check("single_count", 32'(d_err_count), 1);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            send(0, 0);
            if (d_err_pulse) pulses++;
        end
        check("single_no_more", 32'(pulses), 0);
        check("single_locked", 32'(d_locked), 1);
        check("single_bit_count", 32'(d_bit_count), 178);

        // 7 errors in each of two consecutive windows keep lock
        do_reset();
        rand_stream();
        for (int i = 0; i < 23; i++) send(0, 0);
        check("win_locked_start", 32'(d_locked), 1);
        for (int w = 0; w < 2; w++) begin
            pick(7, mask);
            for (int k = 0; k < 64; k++) send(mask[k], 0);
        end
        check("win_locked_end", 32'(d_locked), 1);
        check("win_err_count", 32'(d_err_count), 14);

        // 8 errors within one window lose lock, then relock after 23 good bits
        do_reset();
        rand_stream();
        for (int i = 0; i < 23; i++) send(0, 0);
        pick(8, mask);
        last = 0;
        for (int k = 0; k < 64; k++) if (mask[k]) last = k;
        for (int k = 0; k <= last; k++) begin
            send(mask[k], 0);
            if (k == last - 1) check("loss_still_locked", 32'(d_locked), 1);
        end
        check("loss_unlocked", 32'(d_locked), 0);
        check("loss_state", 32'(d_state), 0);
        check("loss_err_count", 32'(d_err_count), 8);
        for (int j = 1; j <= 23; j++) begin
            send(0, 0);
            if (j == 22) check("relock_22", 32'(d_locked), 0);
        end
        check("relock_23", 32'(d_locked), 1);

        // all-zero input never leaves SEARCH; gapped stream locks on accepted bits only
        do_reset();
        for (int i = 0; i < 30; i++) begin
            tick(1, 0, 0);
            check("zeros_search", 32'(d_state), 0);
        end
        rand_stream();
        for (int j = 0; j < 23; j++) begin
            send(0, 0);
            tick(0, 1'($urandom), 0);
        end
        check("gap_locked", 32'(d_locked), 1);
        check("gap_sat_locked", 32'(s_locked), 1);

        // saturation and clr priority on the CNT_W=4 instance
        for (int i = 0; i < 20; i++) begin
            send(1, 0);
            for (int k = 0; k < 3; k++) send(0, 0);
        end
        check("sat_err_count", 32'(s_err_count), 15);
        check("sat_still_locked", 32'(s_locked), 1);
        send(1, 1);
        check("clr_err_count", 32'(s_err_count), 0);
        check("clr_bit_count", 32'(s_bit_count), 0);

        // random traffic: gaps, sparse errors, occasional clr
        rand_stream();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) != 0)
                send(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 99) == 0));
            else
                tick(0, 1'($urandom), 1'($urandom_range(0, 99) == 0));
        end

        // asynchronous reset between clock edges
        @(negedge clk);
        rst = 1;
        #1;
        check("arst_state", 32'(d_state), 0);
        check("arst_locked", 32'(d_locked), 0);
        check("arst_pulse", 32'(d_err_pulse), 0);
        check("arst_err_count", 32'(d_err_count), 0);
        check("arst_bit_count", 32'(d_bit_count), 0);
        check("arst_s_counts", 32'({s_err_count, s_bit_count}), 0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
Serial receiver/checker for the 7-bit PRBS stream produced by the team's x^7+x^3+1 LFSR generator. It self-synchronises to the incoming bit stream, declares lock, then predicts each bit and counts mismatches. It is used on the receive side of loopback and link tests and drives error and lock status to the display/FSM logic.

Parameters:
SYNC_LEN, 16, consecutive correct predictions needed in VERIFY to declare lock (1..255)
WIN, 64, lock-monitor window length in accepted bits (2..65535)
LOSS_THRESH, 8, errors within one window that force loss of lock (1..WIN)
CNT_W, 16, width of err_count and bit_count

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
en  input  1  bit_in valid this cycle; all state advances only when en=1
bit_in  input  1  received serial PRBS bit
clr  input  1  synchronous clear of err_count and bit_count
locked  output  1  high while in LOCKED
err_pulse  output  1  one-cycle pulse: mismatch detected while LOCKED
err_count  output  CNT_W  saturating count of mismatches while LOCKED
bit_count  output  CNT_W  saturating count of bits checked while LOCKED
state  output  2  00=SEARCH, 01=VERIFY, 10=LOCKED (11 unused)

Behaviour:
- History register h[7:1]: h[1] is the newest bit and h[k] is the bit received k bits ago. Each accepted bit shifts h <= {h[6:1], new_bit}.
- The predicted bit is exp = h[7]^h[3]. This matches the generator recurrence b(n) = b(n-7)^b(n-3).
- Reset: state=SEARCH, h=0, fill_cnt=0, ok_cnt=0, win_cnt=0, win_err=0, locked=0, err_pulse=0, err_count=0, bit_count=0.
- When en=0: no register changes, except err_pulse<=0 and clr is still honoured.
- SEARCH:
  - Each en shifts bit_in into h and increments fill_cnt, saturating at 7.
  - When fill_cnt is 7 after this bit and the resulting h is non-zero, go to VERIFY with ok_cnt=0.
  - If h is all-zero, stay in SEARCH. All-zero is a lock-up state and is never accepted.
- VERIFY:
  - Each en shifts bit_in (the received bit, not exp) into h.
  - If bit_in==exp, ok_cnt++. When ok_cnt reaches SYNC_LEN, go to LOCKED, clear win_cnt and win_err, and set locked=1 on that same edge.
  - If bit_in!=exp, ok_cnt=0 and stay in VERIFY.
  - If the updated h would be all-zero, go to SEARCH with fill_cnt=0.
- LOCKED:
  - Each en shifts exp (the prediction) into h, so line errors do not corrupt the history.
  - mismatch = bit_in!=exp.
  - err_pulse<=mismatch, registered: it is high in the cycle after the edge that sampled the bad bit.
  - err_count += mismatch, saturating at all-ones.
  - bit_count += 1, saturating at all-ones.
  - win_err += mismatch and win_cnt++.
  - If win_err+mismatch >= LOSS_THRESH: go to SEARCH, fill_cnt=0, ok_cnt=0, locked<=0 on that edge. Counters hold their values.
  - Else if win_cnt==WIN-1: win_cnt=0 and win_err=0. The closing bit's error is evaluated against the threshold before the window is cleared.
- clr=1: err_count and bit_count go to 0 on the next edge. clr has priority over a same-cycle increment. It does not affect FSM state, h, or the window counters.
- Minimum lock latency from reset: 7 fill bits + SYNC_LEN matches. With defaults, locked rises on the edge that samples accepted bit #23.
- Asynchronous rst mid-operation returns every register to its reset value immediately.
- Generator phase and seed are irrelevant: any non-zero 7-bit window of a valid stream locks.

Test Plan:
- Lock: drive the stream of an LFSR seeded 7'h01 with en=1 every cycle. Required: state goes 00 -> 01 after bit 7, locked=1 after bit 23, then err_count=0 and bit_count=N-23 after N bits.
- Single error: once locked, invert one bit. Required: exactly one err_pulse, one cycle after that bit; err_count=1; locked stays 1; the next 100 bits give no further pulses, because the history was not corrupted.
- Loss of lock: once locked, invert 8 bits within 64. Required: locked falls on the edge that samples the 8th bad bit and state=00; it relocks 23 bits after errors stop.
- Window reset: once locked, inject 7 errors in window 1 and 7 errors in window 2. Required: lock is held, err_count=14.
- All-zero and gaps: feed 30 zero bits, then a valid stream with en toggled 1/0 each cycle. Required: stays in SEARCH during the zeros and never enters VERIFY on zeros; then locks after 23 accepted bits, so en=0 cycles are ignored.
- clr/saturation/reset: with CNT_W=4, force 20 errors below the loss threshold (WIN=64, LOSS_THRESH=64). Required: err_count saturates at 15; clr together with an error clears it to 0; rst mid-stream zeroes all outputs asynchronously.
